// File: rtl/uart_defs.sv
// ---------------------------------------------------------------------------
// uart_defs
// Shared definitions for the UART receive front-end and its sibling blocks:
// the sampler FSM state type, the default oversampling ratio and the frame
// length, plus a small majority-vote helper.
// ---------------------------------------------------------------------------
package uart_defs;

   // Oversampling ticks per bit time and bits per frame
   // (1 start + 8 data + 1 parity + 1 stop).
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } RxSampState_t;

   // Two-out-of-three vote used at every bit centre.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler_if
// Qualified-bit stream from the RX sampler to the RX deframer.
//   bit_tick      : one-cycle strobe, bit_val carries a new qualified bit
//   bit_val       : majority-voted bit value, held between strobes
//   frame_active  : high from start-bit detection until the stop decision
//   error_framing : one-cycle pulse, stop bit sampled as 0
//   break_detect  : one-cycle pulse, every bit of the frame sampled as 0
// The sampler drives the master modport, the deframer uses the slave one.
// ---------------------------------------------------------------------------
interface uart_rx_sampler_if;

   logic bit_tick;
   logic bit_val;
   logic frame_active;
   logic error_framing;
   logic break_detect;

   modport master (
      output bit_tick,
      output bit_val,
      output frame_active,
      output error_framing,
      output break_detect
   );

   modport slave (
      input bit_tick,
      input bit_val,
      input frame_active,
      input error_framing,
      input break_detect
   );

endinterface

// File: rtl/uart_baud_prescaler.sv
// ---------------------------------------------------------------------------
// uart_baud_prescaler
// Divides clk down to the oversampling rate. pre_cnt runs 0..baud_div and
// os_tick is high in the cycle where pre_cnt equals the divisor, so the tick
// period is baud_div+1 clk cycles. Shared by the RX and TX paths.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   enable   : when low the counter is held at 0 and no tick is produced
//   baud_div : oversample period minus 1, in clk cycles
//   os_tick  : one-cycle oversampling strobe
// ---------------------------------------------------------------------------
module uart_baud_prescaler #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] baud_div,
   output logic                 os_tick
);

   logic [DIV_WIDTH-1:0] pre_cnt;
   logic [DIV_WIDTH-1:0] div_q;

   // The divisor in use is captured only at a wrap (or while disabled), so a
   // change of baud_div never truncates or stretches the running period.
   assign os_tick = enable && (pre_cnt == div_q);

   // Period counter: held while disabled, wraps to 0 on each tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         div_q   <= '0;
      end else if (!enable) begin
         pre_cnt <= '0;
         div_q   <= baud_div;
      end else if (os_tick) begin
         pre_cnt <= '0;
         div_q   <= baud_div;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Front-end of the UART receive path. Synchronises the RX pad, oversamples it
// at the prescaled rate, majority-votes three samples around each bit centre
// and hands one qualified bit per bit time to the deframer. False start bits
// are dropped silently; a 0 stop bit raises error_framing and, if the whole
// frame was 0, break_detect as well.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   rx_pad   : raw asynchronous RX line, idle high
//   enable   : receiver enable
//   baud_div : oversample period minus 1, in clk cycles
//   bus      : qualified-bit stream (master side of uart_rx_sampler_if)
// ---------------------------------------------------------------------------
module uart_rx_sampler
   import uart_defs::*;
#(
   parameter int OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int DIV_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = UART_FRAME_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_pad,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] baud_div,
   uart_rx_sampler_if.master    bus
);

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(FRAME_BITS);

   // Sample points straddle the bit centre; the decision is taken on the last.
   localparam logic [OS_W-1:0]  SAMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  SAMP_B   = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0]  SAMP_C   = OS_W'(OVERSAMPLE / 2 + 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   os_tick;

   RxSampState_t     state, state_next;
   logic [OS_W-1:0]  os_cnt, os_cnt_next;
   logic [IDX_W-1:0] bit_idx, bit_idx_next, bit_idx_inc;
   logic [1:0]       samp, samp_next;
   logic             all_zero, all_zero_next;
   logic             vote;
   logic             decide;

   logic tick_q, tick_next;
   logic val_q, val_next;
   logic active_q, active_next;
   logic ferr_q, ferr_next;
   logic brk_q, brk_next;

   uart_baud_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .baud_div (baud_div),
      .os_tick  (os_tick)
   );

   // Input synchroniser. Flops reset to 1 so the idle line is not mistaken
   // for a start bit straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(rx_pad);
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // The third sample is used directly from rx_s in the decision cycle.
   assign vote        = majority3(samp[0], samp[1], rx_s);
   assign decide      = os_tick && (os_cnt == SAMP_C);
   assign bit_idx_inc = bit_idx + 1'b1;

   // Next-state and next-output logic. Everything is registered, so bit_tick
   // and the error pulses appear in the clk after the deciding os_tick.
   always_comb begin
      state_next    = state;
      os_cnt_next   = os_cnt;
      bit_idx_next  = bit_idx;
      samp_next     = samp;
      all_zero_next = all_zero;
      tick_next     = 1'b0;
      val_next      = val_q;
      active_next   = active_q;
      ferr_next     = 1'b0;
      brk_next      = 1'b0;

      if (!enable) begin
         state_next   = IDLE;
         os_cnt_next  = '0;
         bit_idx_next = '0;
         active_next  = 1'b0;
      end else if (os_tick) begin
         if (os_cnt == SAMP_A) begin
            samp_next[0] = rx_s;
         end
         if (os_cnt == SAMP_B) begin
            samp_next[1] = rx_s;
         end
         os_cnt_next = (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;

         unique case (state)
            IDLE: begin
               // The detecting tick is not counted; the first START tick is 0.
               os_cnt_next = '0;
               if (!rx_s) begin
                  state_next  = START;
                  active_next = 1'b1;
               end
            end

            START: begin
               if (decide) begin
                  if (vote) begin
                     state_next  = IDLE;
                     active_next = 1'b0;
                  end else begin
                     tick_next     = 1'b1;
                     val_next      = 1'b0;
                     bit_idx_next  = IDX_W'(1);
                     all_zero_next = 1'b1;
                     state_next    = DATA;
                  end
               end
            end

            DATA: begin
               if (decide) begin
                  tick_next     = 1'b1;
                  val_next      = vote;
                  all_zero_next = all_zero & ~vote;
                  bit_idx_next  = bit_idx_inc;
                  if (bit_idx_inc == LAST_IDX) begin
                     state_next = STOP;
                  end
               end
            end

            STOP: begin
               if (decide) begin
                  tick_next    = 1'b1;
                  val_next     = vote;
                  active_next  = 1'b0;
                  bit_idx_next = '0;
                  if (vote) begin
                     state_next = IDLE;
                  end else begin
                     ferr_next  = 1'b1;
                     brk_next   = all_zero;
                     state_next = RECOVER;
                  end
               end
            end

            RECOVER: begin
               // Wait for the line to return high so a break is not re-read
               // as a stream of start bits.
               if (rx_s) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         os_cnt   <= '0;
         bit_idx  <= '0;
         samp     <= '0;
         all_zero <= 1'b0;
         tick_q   <= 1'b0;
         val_q    <= 1'b1;
         active_q <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
      end else begin
         state    <= state_next;
         os_cnt   <= os_cnt_next;
         bit_idx  <= bit_idx_next;
         samp     <= samp_next;
         all_zero <= all_zero_next;
         tick_q   <= tick_next;
         val_q    <= val_next;
         active_q <= active_next;
         ferr_q   <= ferr_next;
         brk_q    <= brk_next;
      end
   end

   assign bus.bit_tick      = tick_q;
   assign bus.bit_val       = val_q;
   assign bus.frame_active  = active_q;
   assign bus.error_framing = ferr_q;
   assign bus.break_detect  = brk_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler: nominal frame, false start, glitch,
// break, divided back-to-back frames, enable drop and reset mid-frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_sampler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_pad = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] baud_div = 16'd0;

   int checks = 0;
   int errors = 0;

   // Monitor state, sampled on the falling edge.
   int          cyc = 0;
   int          tick_count;
   logic [31:0] tick_word;
   int          last_tick_cyc;
   int          gap_min;
   int          gap_max;
   int          ferr_count;
   int          brk_count;
   int          ferr_at;
   int          brk_at;
   int          active_run;
   int          active_max;
   int          fall_cyc;
   logic        prev_active = 1'b0;

   uart_rx_sampler_if bus ();

   uart_rx_sampler #(
      .OVERSAMPLE  (16),
      .DIV_WIDTH   (16),
      .SYNC_STAGES (2),
      .FRAME_BITS  (11)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_pad   (rx_pad),
      .enable   (enable),
      .baud_div (baud_div),
      .bus      (bus)
   );

   // 10 ns system clock.
   always #5 clk = ~clk;

   // Records every tick, its value and spacing, the error pulses and the
   // frame_active envelope.
   always @(negedge clk) begin
      int gap;
      cyc++;
      if (bus.bit_tick) begin
         if (tick_count < 32) tick_word[tick_count] = bus.bit_val;
         if (tick_count > 0) begin
            gap = cyc - last_tick_cyc;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
         end
         last_tick_cyc = cyc;
         tick_count++;
      end
      if (bus.error_framing) begin
         ferr_count++;
         ferr_at = bus.bit_tick ? tick_count : -1;
      end
      if (bus.break_detect) begin
         brk_count++;
         brk_at = bus.bit_tick ? tick_count : -1;
      end
      if (bus.frame_active) begin
         active_run++;
         if (active_run > active_max) active_max = active_run;
      end else begin
         active_run = 0;
      end
      if (prev_active && !bus.frame_active) fall_cyc = cyc;
      prev_active = bus.frame_active;
   end

   // Hard stop in case something never returns.
   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic clearMonitor();
      tick_count    = 0;
      tick_word     = '0;
      last_tick_cyc = 0;
      gap_min       = 32'h7fff_ffff;
      gap_max       = 0;
      ferr_count    = 0;
      brk_count     = 0;
      ferr_at       = 0;
      brk_at        = 0;
      active_max    = 0;
      fall_cyc      = -1;
   endtask

   // Wait n falling edges, then step off the edge before looking at results.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   // Frame bits in line order: index 0 is the start bit.
   function automatic logic [10:0] frameBits(input logic [7:0] data,
                                            input logic par, input logic stp);
      return {stp, par, data, 1'b0};
   endfunction

   // Drive one frame LSB-first; glitch_bit selects a bit whose 9th clk
   // (index 8) is inverted for one cycle, -1 for none.
   task automatic applyStimulus(input logic [7:0] data, input logic par,
                                input logic stp, input int clk_per_bit,
                                input int glitch_bit);
      logic [10:0] f;
      f = frameBits(data, par, stp);
      for (int i = 0; i < 11; i++) begin
         rx_pad = f[i];
         if (i == glitch_bit) begin
            repeat (8) @(negedge clk);
            rx_pad = ~f[i];
            @(negedge clk);
            rx_pad = f[i];
            repeat (clk_per_bit - 9) @(negedge clk);
         end else begin
            repeat (clk_per_bit) @(negedge clk);
         end
      end
      rx_pad = 1'b1;
   endtask

   task automatic waitTicks(input string tag, input int n);
      for (int k = 0; k < 2000 && tick_count < n; k++) begin
         @(negedge clk);
         #1;
      end
      checkOutput(tag, (tick_count >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      clearMonitor();
      active_run = 0;

      // Reset values.
      repeat (3) @(negedge clk);
      #2;
      checkOutput("reset_outputs",
                  {bus.bit_tick, bus.bit_val, bus.frame_active,
                   bus.error_framing, bus.break_detect}, 5'b01000);
      rst_n = 1'b1;
      idle(2);
      enable = 1'b1;
      idle(20);

      // Nominal 0xA5 frame, 16 clk per bit.
      clearMonitor();
      applyStimulus(8'hA5, 1'b0, 1'b1, 16, -1);
      idle(20);
      checkOutput("nom_count", tick_count, 11);
      checkOutput("nom_bits", tick_word, {21'b0, frameBits(8'hA5, 1'b0, 1'b1)});
      checkOutput("nom_gap_min", gap_min, 16);
      checkOutput("nom_gap_max", gap_max, 16);
      checkOutput("nom_errors", ferr_count + brk_count, 0);
      checkOutput("nom_active_fall", fall_cyc, last_tick_cyc);
      checkOutput("nom_active_end", bus.frame_active, 0);

      // False start: 4 clk low pulse.
      clearMonitor();
      rx_pad = 1'b0;
      repeat (4) @(negedge clk);
      rx_pad = 1'b1;
      idle(30);
      checkOutput("fs_count", tick_count, 0);
      checkOutput("fs_active_len",
                  (active_max >= 1 && active_max <= 10) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("fs_active_end", bus.frame_active, 0);

      // Glitch on the middle of data bit 2 (line bit 3).
      clearMonitor();
      applyStimulus(8'hA5, 1'b0, 1'b1, 16, 3);
      idle(20);
      checkOutput("gl_count", tick_count, 11);
      checkOutput("gl_bits", tick_word, {21'b0, frameBits(8'hA5, 1'b0, 1'b1)});
      checkOutput("gl_errors", ferr_count + brk_count, 0);

      // Line break: 300 clk low, then idle, then a normal frame.
      clearMonitor();
      rx_pad = 1'b0;
      repeat (300) @(negedge clk);
      rx_pad = 1'b1;
      idle(40);
      checkOutput("brk_count_ticks", tick_count, 11);
      checkOutput("brk_bits", tick_word, 0);
      checkOutput("brk_ferr_count", ferr_count, 1);
      checkOutput("brk_brk_count", brk_count, 1);
      checkOutput("brk_ferr_at", ferr_at, 11);
      checkOutput("brk_brk_at", brk_at, 11);
      checkOutput("brk_active_end", bus.frame_active, 0);
      applyStimulus(8'hA5, 1'b0, 1'b1, 16, -1);
      idle(20);
      checkOutput("brk_next_count", tick_count, 22);
      checkOutput("brk_next_bits", tick_word[21:11], frameBits(8'hA5, 1'b0, 1'b1));
      checkOutput("brk_next_ferr", ferr_count, 1);

      // baud_div=3, frames 0x00 and 0xFF back to back.
      enable = 1'b0;
      baud_div = 16'd3;
      idle(2);
      enable = 1'b1;
      idle(10);
      clearMonitor();
      applyStimulus(8'h00, 1'b0, 1'b1, 64, -1);
      applyStimulus(8'hFF, 1'b0, 1'b1, 64, -1);
      idle(80);
      checkOutput("div_count", tick_count, 22);
      checkOutput("div_bits", tick_word,
                  {10'b0, frameBits(8'hFF, 1'b0, 1'b1), frameBits(8'h00, 1'b0, 1'b1)});
      checkOutput("div_gap_min", gap_min, 64);
      checkOutput("div_gap_max", gap_max, 64);
      checkOutput("div_errors", ferr_count + brk_count, 0);

      enable = 1'b0;
      baud_div = 16'd0;
      idle(2);
      enable = 1'b1;
      idle(10);

      // Enable dropped after the 4th tick.
      clearMonitor();
      fork
         applyStimulus(8'hA5, 1'b0, 1'b1, 16, -1);
         begin
            waitTicks("en_wait", 4);
            enable = 1'b0;
            @(negedge clk);
            #1;
            checkOutput("en_active_off", bus.frame_active, 0);
         end
      join
      idle(20);
      checkOutput("en_count", tick_count, 4);
      checkOutput("en_active_end", bus.frame_active, 0);
      enable = 1'b1;
      idle(10);

      // Reset asserted after the 4th tick of a 0x00 frame.
      clearMonitor();
      fork
         applyStimulus(8'h00, 1'b0, 1'b1, 16, -1);
         begin
            waitTicks("rst_wait", 4);
            checkOutput("rst_pre_state", {bus.bit_val, bus.frame_active}, 2'b01);
            rst_n = 1'b0;
            #1;
            checkOutput("rst_outputs",
                        {bus.bit_tick, bus.bit_val, bus.frame_active,
                         bus.error_framing, bus.break_detect}, 5'b01000);
         end
      join
      idle(20);
      checkOutput("rst_count", tick_count, 4);
      rst_n = 1'b1;
      idle(20);
      checkOutput("rst_release_count", tick_count, 4);

      // Receiver works normally again after reset.
      clearMonitor();
      applyStimulus(8'h3C, 1'b0, 1'b1, 16, -1);
      idle(20);
      checkOutput("post_count", tick_count, 11);
      checkOutput("post_bits", tick_word, {21'b0, frameBits(8'h3C, 1'b0, 1'b1)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
